mem_wb_skid: RTL and testbench

- Parametrised MEM/WB pipeline stage register between data-memory access and register-file write-back.
- Replaces the plain always-load stage with a valid/ready handshake and a 2-entry skid buffer, so write-back can stall without dropping in-flight results.
- Adds flush, occupancy reporting, write-back data selection and $zero write suppression.
- Upstream is EX_MEM/RAM; downstream is the register-file write port and the forwarding unit.

---
 rtl/pipe_pkg.sv | 34 +++
 rtl/pipe_skid_buf.sv | 102 ++++++++++
 rtl/mem_wb_skid.sv | 101 ++++++++++
 tb/tb_mem_wb_skid.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared types and constants for the pipeline-stage register slice.
//
//   skid_state_t : occupancy-encoded state of the 2-entry skid buffer
//                  (EMPTY=0, ONE=1, TWO=2). The encoding doubles as the
//                  occupancy count, so the state is visible to checkers
//                  through the occupancy output.
//   wb_payload_t : MEM/WB payload at the default datapath widths. Stages
//                  with non-default widths declare a local struct of the
//                  same field order.
//   ZERO_REG     : architectural $zero register index.
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int PKG_DATA_W = 32;
  localparam int PKG_REG_W  = 5;
  localparam int ZERO_REG   = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  typedef struct packed {
    logic                  mem_to_reg;
    logic                  reg_write;
    logic [PKG_DATA_W-1:0] read_data;
    logic [PKG_DATA_W-1:0] alu_result;
    logic [PKG_REG_W-1:0]  write_reg;
  } wb_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
//   Generic 2-entry valid/ready skid buffer with flush.
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. inReady depends only on state (and reset), never on outReady,
//   so there is no combinational ready path through this stage. A producer
//   may hold inValid high across cycles until inReady is seen.
//
//   Ports
//     clk, rst   : clock; asynchronous active-high reset
//     inValid    : upstream offers inData
//     inReady    : buffer can take an entry (not full, not in reset)
//     inData     : payload offered by upstream
//     flush      : discard held entries and the entry offered this cycle
//     outValid   : head entry (outData) is valid
//     outReady   : downstream consumes the head this cycle
//     outData    : head payload; holds its last value when outValid is low
//     occupancy  : held entries 0..2; this is also the FSM state encoding
// -----------------------------------------------------------------------------
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [PAYLOAD_W-1:0] inData,
  input  logic                 flush,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [PAYLOAD_W-1:0] outData,
  output logic [1:0]           occupancy
);

  skid_state_t            stateQ;
  skid_state_t            curState;
  logic [PAYLOAD_W-1:0]   mainQ;   // head entry, always older than skidQ
  logic [PAYLOAD_W-1:0]   skidQ;
  logic                   accept;
  logic                   drain;

  // Unreachable encodings decode to EMPTY so the buffer self-recovers.
  always_comb begin
    curState = EMPTY;
    case (stateQ)
      EMPTY:   curState = EMPTY;
      ONE:     curState = ONE;
      TWO:     curState = TWO;
      default: curState = EMPTY;
    endcase
  end

  assign inReady   = !rst && (curState != TWO);
  assign outValid  = (curState != EMPTY);
  assign outData   = mainQ;
  assign occupancy = curState;

  assign accept = inValid && inReady && !flush;
  assign drain  = outValid && outReady;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= EMPTY;
      mainQ  <= '0;
      skidQ  <= '0;
    end else if (flush) begin
      // A same-cycle drain has already been taken by downstream; payload
      // registers are left as they are.
      stateQ <= EMPTY;
    end else begin
      case (curState)
        EMPTY: begin
          if (accept) begin
            stateQ <= ONE;
            mainQ  <= inData;
          end
        end
        ONE: begin
          if (accept && drain) begin
            mainQ <= inData;
          end else if (accept) begin
            stateQ <= TWO;
            skidQ  <= inData;
          end else if (drain) begin
            stateQ <= EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            stateQ <= ONE;
            mainQ  <= skidQ;
          end
        end
        default: stateQ <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/mem_wb_skid.sv
// -----------------------------------------------------------------------------
// mem_wb_skid
//   MEM/WB pipeline stage register with valid/ready handshake and a 2-entry
//   skid buffer, so register-file write-back can stall without losing
//   in-flight results.
//
//   Ports
//     clk, rst                 : clock; asynchronous active-high reset
//     in_valid / in_ready      : upstream handshake (EX_MEM / data RAM)
//     in_mem_to_reg            : write-back source select (1 = memory)
//     in_reg_write             : entry writes the register file
//     in_read_data             : data-memory read value
//     in_alu_result            : ALU result / address
//     in_write_reg             : destination register index
//     flush                    : drop all held entries and the offered one
//     out_valid / out_ready    : downstream handshake (RF write port)
//     out_mem_to_reg, out_read_data, out_alu_result, out_write_reg
//                              : head entry fields
//     out_wb_data              : selected write-back value
//     out_reg_write            : gated RF write enable ($zero suppressed)
//     occupancy                : held entries 0..2
// -----------------------------------------------------------------------------
module mem_wb_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int REG_W          = 5,
  parameter bit ZERO_REG_GUARD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mem_to_reg,
  input  logic              in_reg_write,
  input  logic [DATA_W-1:0] in_read_data,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [REG_W-1:0]  in_write_reg,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_mem_to_reg,
  output logic [DATA_W-1:0] out_read_data,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [REG_W-1:0]  out_write_reg,
  output logic [DATA_W-1:0] out_wb_data,
  output logic              out_reg_write,
  output logic [1:0]        occupancy
);

  // Same field order as pipe_pkg::wb_payload_t, sized by this instance.
  typedef struct packed {
    logic              mem_to_reg;
    logic              reg_write;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_result;
    logic [REG_W-1:0]  write_reg;
  } payload_t;

  localparam int PAYLOAD_W = $bits(payload_t);

  payload_t inPayload;
  payload_t headPayload;
  logic     notZeroReg;

  assign inPayload.mem_to_reg = in_mem_to_reg;
  assign inPayload.reg_write  = in_reg_write;
  assign inPayload.read_data  = in_read_data;
  assign inPayload.alu_result = in_alu_result;
  assign inPayload.write_reg  = in_write_reg;

  pipe_skid_buf #(
    .PAYLOAD_W (PAYLOAD_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .inValid   (in_valid),
    .inReady   (in_ready),
    .inData    (inPayload),
    .flush     (flush),
    .outValid  (out_valid),
    .outReady  (out_ready),
    .outData   (headPayload),
    .occupancy (occupancy)
  );

  assign out_mem_to_reg = headPayload.mem_to_reg;
  assign out_read_data  = headPayload.read_data;
  assign out_alu_result = headPayload.alu_result;
  assign out_write_reg  = headPayload.write_reg;

  assign out_wb_data = headPayload.mem_to_reg ? headPayload.read_data
                                              : headPayload.alu_result;

  // Writes to $zero are architecturally discarded; suppress them here so
  // the forwarding unit never sees a bogus producer for register 0.
  assign notZeroReg    = ZERO_REG_GUARD ? (headPayload.write_reg != REG_W'(ZERO_REG))
                                        : 1'b1;
  assign out_reg_write = out_valid && headPayload.reg_write && notZeroReg;

endmodule

// File: tb/tb_mem_wb_skid.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_skid
//   Directed self-checking bench for mem_wb_skid. Inputs change 1 time unit
//   after the rising edge; outputs are checked at that same point, after
//   they have settled from the edge.
// -----------------------------------------------------------------------------
module tb_mem_wb_skid;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              in_mem_to_reg;
  logic              in_reg_write;
  logic [DATA_W-1:0] in_read_data;
  logic [DATA_W-1:0] in_alu_result;
  logic [REG_W-1:0]  in_write_reg;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic              out_mem_to_reg;
  logic [DATA_W-1:0] out_read_data;
  logic [DATA_W-1:0] out_alu_result;
  logic [REG_W-1:0]  out_write_reg;
  logic [DATA_W-1:0] out_wb_data;
  logic              out_reg_write;
  logic [1:0]        occupancy;

  int checks = 0;
  int errors = 0;

  mem_wb_skid #(
    .DATA_W         (DATA_W),
    .REG_W          (REG_W),
    .ZERO_REG_GUARD (1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_mem_to_reg  (in_mem_to_reg),
    .in_reg_write   (in_reg_write),
    .in_read_data   (in_read_data),
    .in_alu_result  (in_alu_result),
    .in_write_reg   (in_write_reg),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_mem_to_reg (out_mem_to_reg),
    .out_read_data  (out_read_data),
    .out_alu_result (out_alu_result),
    .out_write_reg  (out_write_reg),
    .out_wb_data    (out_wb_data),
    .out_reg_write  (out_reg_write),
    .occupancy      (occupancy)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic v, input logic m2r, input logic rw,
                       input logic [31:0] rd, input logic [31:0] alu,
                       input logic [4:0] wr);
    in_valid      = v;
    in_mem_to_reg = m2r;
    in_reg_write  = rw;
    in_read_data  = rd;
    in_alu_result = alu;
    in_write_reg  = wr;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    offer(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);

    // ---- reset state ----
    step();
    step();
    chk("rst_occ",       32'(occupancy),     32'd0);
    chk("rst_out_valid", 32'(out_valid),     32'd0);
    chk("rst_in_ready",  32'(in_ready),      32'd0);
    chk("rst_reg_write", 32'(out_reg_write), 32'd0);
    chk("rst_wb_data",   out_wb_data,        32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // ---- streaming: one entry per cycle, occupancy stays 1 ----
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 1'b0, 1'b1, 32'hFFFF_0000, 32'h10 + 32'(i), 5'd1);
      step();
      chk($sformatf("stream_wb_%0d", i),    out_wb_data,        32'h10 + 32'(i));
      chk($sformatf("stream_valid_%0d", i), 32'(out_valid),     32'd1);
      chk($sformatf("stream_occ_%0d", i),   32'(occupancy),     32'd1);
      chk($sformatf("stream_rdy_%0d", i),   32'(in_ready),      32'd1);
    end
    offer(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    chk("stream_end_valid", 32'(out_valid),     32'd0);
    chk("stream_end_occ",   32'(occupancy),     32'd0);
    chk("stream_end_rw",    32'(out_reg_write), 32'd0);
    chk("stream_end_hold",  out_wb_data,        32'h13);

    // ---- backpressure: A, B fill; C waits upstream ----
    out_ready = 1'b0;
    offer(1'b1, 1'b0, 1'b1, 32'h0, 32'hA, 5'd2);
    step();
    chk("bp_a_occ", 32'(occupancy), 32'd1);
    chk("bp_a_wb",  out_wb_data,    32'hA);
    offer(1'b1, 1'b0, 1'b1, 32'h0, 32'hB, 5'd2);
    step();
    chk("bp_b_occ", 32'(occupancy), 32'd2);
    chk("bp_b_wb",  out_wb_data,    32'hA);
    chk("bp_b_rdy", 32'(in_ready),  32'd0);
    offer(1'b1, 1'b0, 1'b1, 32'h0, 32'hC, 5'd2);
    step();
    chk("bp_c_held_occ", 32'(occupancy), 32'd2);
    chk("bp_c_held_wb",  out_wb_data,    32'hA);
    chk("bp_c_held_rdy", 32'(in_ready),  32'd0);
    out_ready = 1'b1;
    step();
    chk("bp_drain_b_wb",  out_wb_data,    32'hB);
    chk("bp_drain_b_occ", 32'(occupancy), 32'd1);
    chk("bp_drain_b_rdy", 32'(in_ready),  32'd1);
    step();
    chk("bp_drain_c_wb",  out_wb_data,    32'hC);
    chk("bp_drain_c_occ", 32'(occupancy), 32'd1);
    offer(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    chk("bp_empty_valid", 32'(out_valid), 32'd0);
    chk("bp_empty_occ",   32'(occupancy), 32'd0);

    // ---- flush in TWO with D offered ----
    out_ready = 1'b0;
    offer(1'b1, 1'b0, 1'b1, 32'h0, 32'h21, 5'd4);
    step();
    offer(1'b1, 1'b0, 1'b1, 32'h0, 32'h22, 5'd4);
    step();
    chk("fl_pre_occ", 32'(occupancy), 32'd2);
    offer(1'b1, 1'b0, 1'b1, 32'h0, 32'hD, 5'd4);
    flush = 1'b1;
    step();
    flush = 1'b0;
    offer(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    chk("fl_occ",   32'(occupancy),     32'd0);
    chk("fl_valid", 32'(out_valid),     32'd0);
    chk("fl_rw",    32'(out_reg_write), 32'd0);
    chk("fl_rdy",   32'(in_ready),      32'd1);
    chk("fl_hold",  out_wb_data,        32'h21);
    step();
    chk("fl_no_d_valid", 32'(out_valid), 32'd0);
    chk("fl_no_d_occ",   32'(occupancy), 32'd0);

    // ---- write-back gating and data select ----
    offer(1'b1, 1'b0, 1'b1, 32'h0, 32'h55, 5'd0);
    step();
    chk("wb_zero_valid", 32'(out_valid),     32'd1);
    chk("wb_zero_rw",    32'(out_reg_write), 32'd0);
    chk("wb_zero_data",  out_wb_data,        32'h55);
    out_ready = 1'b1;
    offer(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1234, 5'd3);
    step();
    chk("wb_mem_rw",   32'(out_reg_write), 32'd1);
    chk("wb_mem_data", out_wb_data,        32'hDEAD_BEEF);
    chk("wb_mem_alu",  out_alu_result,     32'h1234);
    chk("wb_mem_reg",  32'(out_write_reg), 32'd3);
    chk("wb_mem_sel",  32'(out_mem_to_reg), 32'd1);
    offer(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    chk("wb_idle_rw",    32'(out_reg_write), 32'd0);
    chk("wb_idle_valid", 32'(out_valid),     32'd0);

    // ---- asynchronous reset while in TWO ----
    out_ready = 1'b0;
    offer(1'b1, 1'b1, 1'b1, 32'h3131, 32'h31, 5'd5);
    step();
    offer(1'b1, 1'b1, 1'b1, 32'h3232, 32'h32, 5'd5);
    step();
    offer(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    chk("ar_pre_occ", 32'(occupancy), 32'd2);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_occ",   32'(occupancy),     32'd0);
    chk("ar_valid", 32'(out_valid),     32'd0);
    chk("ar_rdy",   32'(in_ready),      32'd0);
    chk("ar_rw",    32'(out_reg_write), 32'd0);
    chk("ar_wb",    out_wb_data,        32'h0);
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("ar_rel_rdy", 32'(in_ready), 32'd1);
    step();
    offer(1'b1, 1'b0, 1'b1, 32'h0, 32'h41, 5'd6);
    step();
    offer(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    chk("ar_new_valid", 32'(out_valid),     32'd1);
    chk("ar_new_wb",    out_wb_data,        32'h41);
    chk("ar_new_occ",   32'(occupancy),     32'd1);
    chk("ar_new_rw",    32'(out_reg_write), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
